// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet stream loader.
//   - default data word width and frame length
//   - frame word index map (word 0 = epsilon, words 1..4 = activations)
//   - loader FSM state encoding
package maxnet_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 5;

  localparam int IDX_EPS = 0;
  localparam int IDX_A1  = 1;
  localparam int IDX_A2  = 2;
  localparam int IDX_A3  = 3;
  localparam int IDX_A4  = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/maxnet_frame_regs.sv
// Operand register file for one Maxnet frame.
// Each word of the frame has its own register, written when we_i is high and
// idx_i selects it. All words clear asynchronously on rst.
// Ports:
//   clk, rst  - clock, async active-high reset
//   we_i      - write strobe (one accepted stream word)
//   idx_i     - frame index of the word being written
//   data_i    - word to store
//   words_o   - all frame words, packed, index 0 = epsilon
module maxnet_frame_regs #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 5,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we_i,
  input  logic [IDX_W-1:0]                   idx_i,
  input  logic [DATA_W-1:0]                  data_i,
  output logic [FRAME_LEN-1:0][DATA_W-1:0]   words_o
);

  import maxnet_pkg::*;

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_word
    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                word_q <= '0;
      else if (we_i && idx_i == IDX_W'(g))    word_q <= data_i;
    end

    assign words_o[g] = word_q;
  end

endmodule

// File: rtl/maxnet_stream_loader.sv
// Upstream feeder / result collector for the Maxnet core.
// Collects one frame (epsilon, a1..a4) from a valid/ready word stream, pulses
// core_start for one cycle, waits for a rising edge of core_finish, captures
// core_out/core_overflow and offers them on a valid/ready result port.
// Only one job is in flight at a time.
// Optional feature: define MAXNET_LOADER_TIMEOUT_EN to add a WAIT watchdog
// (parameter TIMEOUT_CYC, extra output res_timeout).
// Ports:
//   clk, rst                          - clock, async active-high reset
//   in_valid/in_ready/in_data         - input word stream
//   core_start, core_epsilon, core_a1..core_a4 - core operand interface
//   core_finish, core_out, core_overflow       - core completion interface
//   res_valid/res_ready/res_data/res_overflow  - result port
//   res_timeout                       - watchdog completion flag (option only)
//   busy                              - high in every state except LOAD
module maxnet_stream_loader #(
  parameter int DATA_W    = maxnet_pkg::DATA_W,
  parameter int FRAME_LEN = maxnet_pkg::FRAME_LEN
`ifdef MAXNET_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              core_start,
  output logic [DATA_W-1:0] core_epsilon,
  output logic [DATA_W-1:0] core_a1,
  output logic [DATA_W-1:0] core_a2,
  output logic [DATA_W-1:0] core_a3,
  output logic [DATA_W-1:0] core_a4,
  input  logic              core_finish,
  input  logic [DATA_W-1:0] core_out,
  input  logic              core_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_overflow,
`ifdef MAXNET_LOADER_TIMEOUT_EN
  output logic              res_timeout,
`endif
  output logic              busy
);

  import maxnet_pkg::*;

  localparam int CNT_W = $clog2(FRAME_LEN);

  state_t                             state_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic                               in_ready_q;
  logic                               core_start_q;
  logic                               res_valid_q;
  logic                               busy_q;
  logic                               fin_q;
  logic [DATA_W-1:0]                  res_data_q;
  logic                               res_ovf_q;
  logic [FRAME_LEN-1:0][DATA_W-1:0]   words;

  logic in_fire;
  logic last_word;
  logic fin_rise;

  assign in_fire   = in_valid & in_ready_q;
  assign last_word = (cnt_q == CNT_W'(FRAME_LEN - 1));
  // fin_q tracks core_finish in every state, so a level still high from the
  // previous job produces no edge until it has been seen low.
  assign fin_rise  = core_finish & ~fin_q;

  maxnet_frame_regs #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (CNT_W)
  ) u_frame (
    .clk     (clk),
    .rst     (rst),
    .we_i    (in_fire),
    .idx_i   (cnt_q),
    .data_i  (in_data),
    .words_o (words)
  );

`ifdef MAXNET_LOADER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            res_to_q;
  logic            to_hit;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      res_data_q   <= '0;
      res_ovf_q    <= 1'b0;
`ifdef MAXNET_LOADER_TIMEOUT_EN
      to_cnt_q     <= '0;
      res_to_q     <= 1'b0;
`endif
    end else begin
      fin_q <= core_finish;
      case (state_q)
        LOAD: begin
          if (in_fire) begin
            if (last_word) begin
              cnt_q        <= '0;
              in_ready_q   <= 1'b0;
              core_start_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= START;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        START: begin
          core_start_q <= 1'b0;
          state_q      <= WAIT;
`ifdef MAXNET_LOADER_TIMEOUT_EN
          to_cnt_q     <= '0;
`endif
        end
        WAIT: begin
          if (fin_rise) begin
            res_data_q  <= core_out;
            res_ovf_q   <= core_overflow;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
`ifdef MAXNET_LOADER_TIMEOUT_EN
            res_to_q    <= 1'b0;
          end else if (to_hit) begin
            // Core never answered: report a forced overflow result.
            res_data_q  <= '0;
            res_ovf_q   <= 1'b1;
            res_to_q    <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else begin
            to_cnt_q    <= to_cnt_q + TO_W'(1);
`endif
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign core_start   = core_start_q;
  assign core_epsilon = words[IDX_EPS];
  assign core_a1      = words[IDX_A1];
  assign core_a2      = words[IDX_A2];
  assign core_a3      = words[IDX_A3];
  assign core_a4      = words[IDX_A4];
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_overflow = res_ovf_q;
  assign busy         = busy_q;
`ifdef MAXNET_LOADER_TIMEOUT_EN
  assign res_timeout  = res_to_q;
`endif

endmodule
